axi4lite_slave_mem: RTL
=======================

Name: axi4lite_slave_mem

Overview:
AXI4-Lite responder backed by a word-organised RAM with byte write strobes. It is the memory-side end of the core's AXI4-Lite master port: it accepts the core's AW/W/AR requests and returns B and R responses. Integration benches and system tops use it as the data memory. Read latency is programmable so the core's wait/stall paths are exercised.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
READ_LATENCY, 1, extra wait cycles between the AR handshake and Rvalid; legal range 0..15.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous reset, active-high.
AWdata  in  32  write byte address.
AWprot  in  3  ignored.
AWvalid  in  1  write address valid.
AWready  out  1  write address accepted.
Wdata  in  32  write data.
Wstrb  in  4  byte lane enables; bit i gates Wdata[8i+7:8i].
Wvalid  in  1  write data valid.
Wready  out  1  write data accepted.
Bvalid  out  1  write response valid.
Bready  in  1  write response accepted.
Bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
ARdata  in  32  read byte address.
ARprot  in  3  ignored.
ARvalid  in  1  read address valid.
ARready  out  1  read address accepted.
Rdata  out  32  read data.
Rvalid  out  1  read data valid.
RReady  in  1  read data accepted.
Rresp  out  2  same encoding as Bresp.

Behaviour:
- Reset: both FSMs go to IDLE. AWready=Wready=ARready=1 from the first cycle after reset. Bvalid=Rvalid=0; Rdata=0; Bresp=Rresp=0. While reset is high, no handshake is honoured and no RAM write happens. RAM contents are not cleared.
- Reset mid-transaction: the transaction is abandoned. An uncommitted write is dropped. Bvalid and Rvalid are 0 on the next cycle.
- Address decode: the low 2 address bits are ignored. idx = (addr - BASE_ADDR) >> 2. The address is in range iff addr >= BASE_ADDR and idx < DEPTH.
- Write FSM states:
  - W_IDLE: AWready=1, Wready=1.
  - W_DATA: address held, waiting for data. AWready=0, Wready=1.
  - W_ADDR: data and strobes held, waiting for address. AWready=1, Wready=0.
  - W_RESP: Bvalid=1, both readies 0.
- Write transitions:
  - AW and W handshakes may arrive in either order or in the same cycle.
  - When both have been captured, the RAM is written in that same edge with the strobed lanes only. The FSM then enters W_RESP, so Bvalid rises on the next cycle.
  - Out-of-range write: no RAM update, Bresp=SLVERR.
  - Bvalid and Bresp hold until Bready=1. The FSM then returns to W_IDLE; readies are high on the following cycle.
  - Wstrb=0 in range: no byte changes, Bresp=OKAY.
- Read FSM states: R_IDLE (ARready=1), R_WAIT (counter), R_DATA (Rvalid=1).
- Read transitions:
  - After the AR handshake the counter loads READ_LATENCY and the FSM enters R_WAIT, or R_DATA directly when READ_LATENCY=0.
  - The counter decrements each cycle in R_WAIT. On the cycle it reads 1, the RAM word is sampled into Rdata and the FSM enters R_DATA.
  - Rvalid therefore rises READ_LATENCY+1 cycles after the AR handshake.
  - Rdata and Rresp are stable while Rvalid=1 and RReady=0. On the handshake the FSM returns to R_IDLE.
  - Out-of-range read: Rdata=0, Rresp=SLVERR.
- Read/write collision: the read and write channels are independent. If a RAM write and a read sample hit the same word in the same cycle, the read returns the pre-write value.
- One outstanding transaction per channel; there is no pipelining of AR or AW beyond one.

Decomposition:
- Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write-state encoding, read-state encoding, and the in-range decode helper function.
- Sub-module mem_bytewrite_ram: DEPTH x 32 array with one synchronous read port and one synchronous write port with a 4-bit byte enable. Reads return old data on a same-address write.

Test Plan:
1. Reset, then AW 0x10 and W 0xA5A5_5A5A with strb 4'hF in the same cycle -> Bvalid high on the next cycle with Bresp=00. Then AR 0x10 with READ_LATENCY=1 -> Rvalid 2 cycles after the AR handshake, Rdata=0xA5A5_5A5A, Rresp=00.
2. W 0x1122_3344 three cycles before AW 0x20 -> Wready=0 while waiting, AWready=1. Write commits on the AW cycle. Read of 0x20 returns 0x1122_3344.
3. Word 0x20 holds 0x1122_3344; write 0xFFFF_FFFF to 0x20 with strb 4'b0101 -> read returns 0x11FF_33FF.
4. With DEPTH=1024 and BASE=0, write to 0x1000 -> Bresp=10 and no RAM change. Read of 0x1000 -> Rdata=0, Rresp=10.
5. Hold Bready=0 and RReady=0 for 5 cycles -> Bvalid, Rvalid, Rdata and Bresp stay stable, and AWready, Wready and ARready stay 0 throughout.
6. Assert reset while in R_WAIT and while in W_DATA -> Rvalid=Bvalid=0 and all readies=1 after reset. Reading the targeted word shows no write occurred.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared response codes, FSM state encodings and address decode for the
// AXI4-Lite memory responder.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_ADDR = 2'd2,
        W_RESP = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    // Low two address bits are don't-care; range is [base, base + 4*depth).
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/axi4lite_slave_mem_if.sv
// AXI4-Lite bus bundle between the core (master) and the memory responder (slave).
interface axi4lite_slave_mem_if;

    // Every channel transfers on a rising edge where its valid and ready are both 1;
    // the source holds payload stable while valid=1 and ready=0.
    logic [31:0] AWdata;
    logic [2:0]  AWprot;
    logic        AWvalid;
    logic        AWready;

    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Wvalid;
    logic        Wready;

    logic        Bvalid;
    logic        Bready;
    logic [1:0]  Bresp;

    logic [31:0] ARdata;
    logic [2:0]  ARprot;
    logic        ARvalid;
    logic        ARready;

    logic [31:0] Rdata;
    logic        Rvalid;
    logic        RReady;
    logic [1:0]  Rresp;

    modport master (
        output AWdata, AWprot, AWvalid, input AWready,
        output Wdata, Wstrb, Wvalid, input Wready,
        input  Bvalid, Bresp, output Bready,
        output ARdata, ARprot, ARvalid, input ARready,
        input  Rdata, Rvalid, Rresp, output RReady
    );

    modport slave (
        input  AWdata, AWprot, AWvalid, output AWready,
        input  Wdata, Wstrb, Wvalid, output Wready,
        output Bvalid, Bresp, input Bready,
        input  ARdata, ARprot, ARvalid, output ARready,
        output Rdata, Rvalid, Rresp, input RReady
    );

endinterface

// File: rtl/mem_bytewrite_ram.sv
// DEPTH x 32 RAM: one synchronous read port, one synchronous byte-enabled write port.
// A read and write to the same word on the same edge returns the old word.
module mem_bytewrite_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite responder in front of a byte-strobed word RAM, with independent
// write and read FSMs and a programmable read wait.
module axi4lite_slave_mem
    import axi4lite_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    axi4lite_slave_mem_if.slave s_axi,
    output wstate_t             o_dbg_wstate,
    output rstate_t             o_dbg_rstate
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(READ_LATENCY);

    // Live decode of the request addresses
    logic [31:0]   w_aw_off, w_ar_off;
    logic [AW-1:0] w_aw_idx, w_ar_idx;
    logic          w_aw_ok,  w_ar_ok;

    assign w_aw_off = s_axi.AWdata - BASE_ADDR;
    assign w_ar_off = s_axi.ARdata - BASE_ADDR;
    assign w_aw_idx = w_aw_off[AW+1:2];
    assign w_ar_idx = w_ar_off[AW+1:2];
    assign w_aw_ok  = addr_in_range(s_axi.AWdata, BASE_ADDR, 32'(DEPTH));
    assign w_ar_ok  = addr_in_range(s_axi.ARdata, BASE_ADDR, 32'(DEPTH));

    logic w_unused_ok;
    assign w_unused_ok = ^{s_axi.AWprot, s_axi.ARprot,
                           w_aw_off[31:AW+2], w_aw_off[1:0],
                           w_ar_off[31:AW+2], w_ar_off[1:0]};

    // ---------------- write channel ----------------
    wstate_t       r_wstate;
    logic          r_awready, r_wready, r_bvalid;
    logic [1:0]    r_bresp;
    logic [AW-1:0] r_aw_idx;
    logic          r_aw_ok;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;

    logic          w_commit, w_wok;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;

    // w_commit marks the edge on which both halves of the write are in hand.
    always_comb begin
        w_commit = 1'b0;
        w_waddr  = w_aw_idx;
        w_wok    = w_aw_ok;
        w_wdata  = s_axi.Wdata;
        w_wstrb  = s_axi.Wstrb;
        case (r_wstate)
            W_IDLE: w_commit = s_axi.AWvalid && s_axi.Wvalid;
            W_DATA: begin
                w_commit = s_axi.Wvalid;
                w_waddr  = r_aw_idx;
                w_wok    = r_aw_ok;
            end
            W_ADDR: begin
                w_commit = s_axi.AWvalid;
                w_wdata  = r_wdata;
                w_wstrb  = r_wstrb;
            end
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi.AWvalid) begin
                        r_aw_idx  <= w_aw_idx;
                        r_aw_ok   <= w_aw_ok;
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                    end else if (s_axi.Wvalid) begin
                        r_wdata  <= s_axi.Wdata;
                        r_wstrb  <= s_axi.Wstrb;
                        r_wstate <= W_ADDR;
                        r_wready <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (s_axi.Bready) begin
                        r_wstate  <= W_IDLE;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_bvalid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rstate_t       r_rstate;
    logic          r_arready, r_rvalid, r_rd_ok;
    logic [1:0]    r_rresp;
    logic [3:0]    r_rcnt;
    logic [AW-1:0] r_ar_idx;
    logic          r_ar_ok;

    logic          w_rsample, w_rok;
    logic [AW-1:0] w_ridx;
    logic [31:0]   w_ram_rdata;

    // With zero latency the RAM is sampled on the AR handshake edge itself.
    always_comb begin
        w_rsample = 1'b0;
        w_ridx    = w_ar_idx;
        w_rok     = w_ar_ok;
        case (r_rstate)
            R_IDLE: w_rsample = s_axi.ARvalid && (LAT == 4'd0);
            R_WAIT: begin
                w_rsample = (r_rcnt == 4'd1);
                w_ridx    = r_ar_idx;
                w_rok     = r_ar_ok;
            end
            default: w_rsample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rd_ok   <= 1'b0;
            r_rcnt    <= '0;
            r_ar_idx  <= '0;
            r_ar_ok   <= 1'b0;
        end else if (w_rsample) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rd_ok   <= w_rok;
            r_rresp   <= w_rok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.ARvalid) begin
                        r_ar_idx  <= w_ar_idx;
                        r_ar_ok   <= w_ar_ok;
                        r_rcnt    <= LAT;
                        r_rstate  <= R_WAIT;
                        r_arready <= 1'b0;
                    end
                end
                R_WAIT: r_rcnt <= r_rcnt - 4'd1;
                R_DATA: begin
                    if (s_axi.RReady) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    mem_bytewrite_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_commit && w_wok && !reset),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_re    (w_rsample && !reset),
        .i_raddr (w_ridx),
        .o_rdata (w_ram_rdata)
    );

    assign s_axi.AWready = r_awready;
    assign s_axi.Wready  = r_wready;
    assign s_axi.Bvalid  = r_bvalid;
    assign s_axi.Bresp   = r_bresp;
    assign s_axi.ARready = r_arready;
    assign s_axi.Rvalid  = r_rvalid;
    assign s_axi.Rresp   = r_rresp;
    assign s_axi.Rdata   = r_rd_ok ? w_ram_rdata : 32'h0;

    assign o_dbg_wstate = r_wstate;
    assign o_dbg_rstate = r_rstate;

endmodule
